frame_timer: RTL and testbench
==============================

Name: frame_timer

Overview:
- Parametrised successor to the fixed-rate frame clock.
- Generates an exact-period frame tick from sysclk. The period is runtime-reloadable.
- Tracks a frame request/acknowledge handshake with the renderer, and counts accepted and dropped frames.
- Produces NUM_CH divided sub-rate ticks aligned to the frame tick, used for animation and UI update rates.

Parameters:
- CLK_HZ, 125000000, sysclk frequency in Hz.
- FPS, 60, default frame rate. DEF_PERIOD = CLK_HZ/FPS (integer divide) is the reset period in cycles.
- CNT_W, 32, width of the period counter and period_in.
- FC_W, 16, width of frame_count.
- DROP_W, 8, width of drop_count (saturating).
- NUM_CH, 2, number of divided tick channels.
- DIV_W, 8, width of each channel divider.

Ports:
- sysclk, in, 1, system clock.
- rst, in, 1, reset; asynchronous, active-high.
- enable, in, 1, 1 = timebase runs; 0 = counter holds.
- period_ld, in, 1, load period_in this cycle.
- period_in, in, CNT_W, new frame period in sysclk cycles.
- frame_ack, in, 1, renderer finished the current frame.
- ch_div, in, NUM_CH*DIV_W, per-channel divider; channel i = bits [i*DIV_W +: DIV_W].
- update, out, 1, one-cycle pulse per period (raw tick).
- frame_req, out, 1, level; frame pending for the renderer.
- frame_count, out, FC_W, accepted frames; wraps modulo 2^FC_W.
- drop_count, out, DROP_W, ticks lost while a frame was pending; saturates at all-ones.
- ch_tick, out, NUM_CH, one-cycle pulse on every ch_div[i]-th tick.

Behaviour:
- **Reset:** rst high asynchronously clears the following:
  - step, update, frame_req, frame_count, drop_count, ch_tick and all channel counters go to 0.
  - period register goes to DEF_PERIOD.
  - Reset mid-frame discards the pending request; no drop is counted.
- **Effective period:** P = max(period register, 2). Loaded values 0 and 1 are stored as-is but behave as 2.
- **Timebase:** while enable=1, step increments each cycle. When step == P-1, a tick occurs that cycle and step returns to 0 next cycle. Ticks are therefore exactly P cycles apart; the first tick after reset is on cycle P-1.
- **enable=0:**
  - step holds and no ticks occur; the phase resumes when enable returns.
  - frame_req, the counters and the handshake are unaffected, so frame_ack is still accepted.
- **Registered outputs:** update and ch_tick are registered; they assert the cycle after the tick cycle and last exactly one cycle.
- **period_ld=1:**
  - period register <= period_in and step <= 0; the tick for this cycle, if any, is suppressed.
  - All channel counters are cleared.
  - It takes priority over enable.
- **Handshake (evaluated on the tick cycle, registered results):**
  - frame_req=0, or frame_req=1 with frame_ack=1 the same cycle: frame_req <= 1 and frame_count += 1.
  - frame_req=1 and frame_ack=0: drop_count += 1 (saturating); frame_req stays 1; frame_count unchanged.
- **Acknowledge outside a tick:** frame_ack=1 with frame_req=1 gives frame_req <= 0 next cycle. frame_ack while frame_req=0 is ignored.
- **Channels:** each tick (accepted or dropped) advances every channel counter c_i.
  - ch_div[i]=0: channel disabled; c_i held at 0 and ch_tick[i] never pulses.
  - ch_div[i]=d≥1: when c_i == d-1, ch_tick[i] pulses together with update and c_i <= 0; otherwise c_i += 1.
  - If ch_div changes while running and c_i ≥ new d, the next tick counts as the terminal count (pulse, c_i <= 0).
- **Width rules:**
  - frame_count wraps from 2^FC_W-1 to 0.
  - drop_count holds at 2^DROP_W-1.
  - step is CNT_W bits; DEF_PERIOD must fit in CNT_W (elaboration assertion).

Test Plan:
- CLK_HZ=1000, FPS=100 (P=10), enable=1, frame_ack pulsed 2 cycles after each update -> update on cycles 10,20,30 (period 10 exactly); frame_count=3; drop_count=0.
- Same setup with frame_ack never asserted for 5 ticks -> frame_req=1 throughout; frame_count=1; drop_count=4. With DROP_W=2 and 6 ticks, drop_count saturates at 3.
- frame_ack on the same cycle as the tick while frame_req=1 -> frame_req stays 1; frame_count increments; no drop.
- period_ld with period_in=4 at step=7 -> no tick that period; next update 4 cycles later, then every 4. period_in=0 -> ticks every 2 cycles.
- enable low for 13 cycles at step=5 -> no update during the gap; next update 4 cycles after re-enable.
- ch_div={3,0,1} (NUM_CH=3) over 6 ticks -> ch_tick[0] on ticks 3,6; ch_tick[1] never; ch_tick[2] every tick, coincident with update. Async rst mid-run -> all outputs 0 immediately; period back to DEF_PERIOD.

Source files
------------

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - reloadable frame tick generator with render handshake and divided sub-rate ticks
`timescale 1ns/1ps

module frame_timer #(
  parameter int CLK_HZ = 125000000,
  parameter int FPS    = 60,
  parameter int CNT_W  = 32,
  parameter int FC_W   = 16,
  parameter int DROP_W = 8,
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8
) (
  input  logic                    sysclk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    period_ld,
  input  logic [CNT_W-1:0]        period_in,
  input  logic                    frame_ack,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  output logic                    update,
  output logic                    frame_req,
  output logic [FC_W-1:0]         frame_count,
  output logic [DROP_W-1:0]       drop_count,
  output logic [NUM_CH-1:0]       ch_tick
);

  localparam longint DEF_WIDE = longint'(CLK_HZ) / longint'(FPS);

  if ((DEF_WIDE >> CNT_W) != 0) begin : g_def_period_chk
    $error("frame_timer: CLK_HZ/FPS does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEF_WIDE);

  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] step_q;
  logic [CNT_W-1:0] p_last;
  logic             tick;

  // Periods of 0 and 1 are kept as loaded but run as 2, so the last step is 1.
  always_comb begin
    p_last = (period_q < CNT_W'(2)) ? CNT_W'(1) : period_q - CNT_W'(1);
    tick   = enable && !period_ld && (step_q == p_last);
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      period_q <= DEF_PERIOD;
      step_q   <= '0;
      update   <= 1'b0;
    end else begin
      update <= tick;
      if (period_ld) begin
        period_q <= period_in;
        step_q   <= '0;
      end else if (enable) begin
        step_q <= tick ? '0 : step_q + CNT_W'(1);
      end
    end
  end

  // An ack landing on the tick cycle both retires the old frame and posts the next.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      frame_req   <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
    end else if (tick) begin
      if (!frame_req || frame_ack) begin
        frame_req   <= 1'b1;
        frame_count <= frame_count + FC_W'(1);
      end else if (drop_count != '1) begin
        drop_count <= drop_count + DROP_W'(1);
      end
    end else if (frame_ack) begin
      frame_req <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt_q;
    logic             pulse_q;
    logic             term;

    assign div = ch_div[i*DIV_W +: DIV_W];
    // Compare with >= so a divider lowered below the running count terminates on the next tick.
    assign term = (div != '0) && (cnt_q >= div - DIV_W'(1));
    assign ch_tick[i] = pulse_q;

    always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= tick && term;
        if (period_ld || div == '0) begin
          cnt_q <= '0;
        end else if (tick) begin
          cnt_q <= term ? '0 : cnt_q + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_timer.sv
// tb/tb_frame_timer.sv - scoreboard bench for frame_timer (P=10 default, 3 channels, narrow counters)
`timescale 1ns/1ps

module tb_frame_timer;
  localparam int CNT_W  = 16;
  localparam int FC_W   = 4;
  localparam int DROP_W = 2;
  localparam int NUM_CH = 3;
  localparam int DIV_W  = 4;

  logic                    sysclk = 1'b0;
  logic                    rst = 1'b1;
  logic                    enable = 1'b0;
  logic                    period_ld = 1'b0;
  logic [CNT_W-1:0]        period_in = '0;
  logic                    frame_ack = 1'b0;
  logic [NUM_CH*DIV_W-1:0] ch_div = '0;
  logic                    update;
  logic                    frame_req;
  logic [FC_W-1:0]         frame_count;
  logic [DROP_W-1:0]       drop_count;
  logic [NUM_CH-1:0]       ch_tick;

  typedef struct {
    int                c;
    logic              req;
    logic [FC_W-1:0]   fc;
    logic [DROP_W-1:0] dc;
    logic [NUM_CH-1:0] ch;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  frame_timer #(
    .CLK_HZ(1000), .FPS(100), .CNT_W(CNT_W), .FC_W(FC_W),
    .DROP_W(DROP_W), .NUM_CH(NUM_CH), .DIV_W(DIV_W)
  ) dut (
    .sysclk(sysclk), .rst(rst), .enable(enable), .period_ld(period_ld),
    .period_in(period_in), .frame_ack(frame_ack), .ch_div(ch_div),
    .update(update), .frame_req(frame_req), .frame_count(frame_count),
    .drop_count(drop_count), .ch_tick(ch_tick)
  );

  always #5 sysclk = ~sysclk;

  // cyc equals the DUT step count while enabled with the default period
  always @(posedge sysclk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic req, input int fc, input int dc,
                      input logic [NUM_CH-1:0] ch);
    exp_t e;
    e.c   = c;
    e.req = req;
    e.fc  = FC_W'(fc);
    e.dc  = DROP_W'(dc);
    e.ch  = ch;
    expq.push_back(e);
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge sysclk);
  endtask

  always @(negedge sysclk) begin
    if (!rst) begin
      if (update) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_update: got update at cycle %0d expected none", cyc);
        end else begin
          mon_e = expq.pop_front();
          chk("update_cycle", 32'(cyc), 32'(mon_e.c));
          chk("frame_req", 32'(frame_req), 32'(mon_e.req));
          chk("frame_count", 32'(frame_count), 32'(mon_e.fc));
          chk("drop_count", 32'(drop_count), 32'(mon_e.dc));
          chk("ch_tick", 32'(ch_tick), 32'(mon_e.ch));
        end
      end else begin
        chk("ch_tick_idle", 32'(ch_tick), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ch_div = {4'd1, 4'd0, 4'd3};
    enable = 1'b1;
    repeat (3) @(negedge sysclk);
    chk("rst_update", 32'(update), 32'd0);
    chk("rst_frame_req", 32'(frame_req), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_ch_tick", 32'(ch_tick), 32'd0);

    // acked ticks, then unacked ticks saturating drops, then same-cycle ack
    push(10, 1, 1, 0, 3'b100);  push(20, 1, 2, 0, 3'b100);  push(30, 1, 3, 0, 3'b101);
    push(40, 1, 4, 0, 3'b100);  push(50, 1, 4, 1, 3'b100);  push(60, 1, 4, 2, 3'b101);
    push(70, 1, 4, 3, 3'b100);  push(80, 1, 4, 3, 3'b100);  push(90, 1, 4, 3, 3'b101);
    push(100, 1, 5, 3, 3'b100);
    // enable gap, then reload to 4 at step 7
    push(123, 1, 6, 3, 3'b100); push(133, 1, 6, 3, 3'b101);
    push(145, 1, 7, 3, 3'b100); push(149, 1, 7, 3, 3'b100); push(153, 1, 7, 3, 3'b101);
    // period 0 runs as 2, ack held high, frame_count wraps, divider lowered mid-run
    push(157, 1, 8, 3, 3'b100);  push(159, 1, 9, 3, 3'b100);  push(161, 1, 10, 3, 3'b101);
    push(163, 1, 11, 3, 3'b100); push(165, 1, 12, 3, 3'b100); push(167, 1, 13, 3, 3'b101);
    push(169, 1, 14, 3, 3'b100); push(171, 1, 15, 3, 3'b100); push(173, 1, 0, 3, 3'b001);
    push(175, 1, 1, 3, 3'b000);  push(177, 1, 1, 3, 3'b001);  push(179, 1, 1, 3, 3'b000);

    rst = 1'b0;
    at_cycle(12);  frame_ack = 1'b1;
    at_cycle(13);  frame_ack = 1'b0;
    at_cycle(22);  frame_ack = 1'b1;
    at_cycle(23);  frame_ack = 1'b0;
    at_cycle(32);  frame_ack = 1'b1;
    at_cycle(33);  frame_ack = 1'b0;

    at_cycle(99);  frame_ack = 1'b1;
    at_cycle(100); frame_ack = 1'b0;
    at_cycle(101); chk("req_kept_after_tick_ack", 32'(frame_req), 32'd1);

    at_cycle(105); enable = 1'b0;
    at_cycle(110); frame_ack = 1'b1;
    at_cycle(111); frame_ack = 1'b0;
    chk("ack_while_disabled", 32'(frame_req), 32'd0);
    at_cycle(118); enable = 1'b1;

    at_cycle(140); period_ld = 1'b1; period_in = 16'd4;
    at_cycle(141); period_ld = 1'b0;
    at_cycle(142); frame_ack = 1'b1;
    at_cycle(143); frame_ack = 1'b0;

    at_cycle(154); period_ld = 1'b1; period_in = 16'd0;
    at_cycle(155); period_ld = 1'b0; frame_ack = 1'b1;
    at_cycle(171); ch_div = {4'd0, 4'd0, 4'd2};
    at_cycle(175); frame_ack = 1'b0;

    at_cycle(180);
    rst = 1'b1;
    #1;
    chk("async_rst_update", 32'(update), 32'd0);
    chk("async_rst_frame_req", 32'(frame_req), 32'd0);
    chk("async_rst_frame_count", 32'(frame_count), 32'd0);
    chk("async_rst_drop_count", 32'(drop_count), 32'd0);
    chk("async_rst_ch_tick", 32'(ch_tick), 32'd0);
    chk("queue_drained_before_rst", 32'(expq.size()), 32'd0);

    // default period restored after reset
    push(10, 1, 1, 0, 3'b000);
    push(20, 1, 1, 1, 3'b001);
    repeat (2) @(negedge sysclk);
    rst = 1'b0;
    at_cycle(25);
    chk("queue_drained_at_end", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
